// File: rtl/m_imem_fetch_port.sv
// Instruction memory fetch port: synchronous-read memory behind a valid/ready request/response
// interface, with fault reporting, flush, a program-load write port and a credit-managed FIFO.
module m_imem_fetch_port #(
    parameter int unsigned DEPTH_WORDS = 1024,
    parameter logic [31:0] BASE_ADDR   = 32'h8000_0000,
    parameter int unsigned READ_LAT    = 1,
    parameter logic [31:0] NOP_INSTR   = 32'h0000_0013,
    parameter string       INIT_FILE   = ""
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           flush,
    input  logic                           req_valid,
    output logic                           req_ready,
    input  logic [31:0]                    req_addr,
    output logic                           rsp_valid,
    input  logic                           rsp_ready,
    output logic [31:0]                    rsp_instr,
    output logic [31:0]                    rsp_addr,
    output logic                           rsp_fault,
    output logic [3:0]                     rsp_cause,
    input  logic                           ld_we,
    input  logic [$clog2(DEPTH_WORDS)-1:0] ld_widx,
    input  logic [31:0]                    ld_data
);

    localparam int unsigned AW        = $clog2(DEPTH_WORDS);
    localparam int unsigned FD        = READ_LAT + 1;
    localparam int unsigned PW        = $clog2(FD);
    localparam int unsigned CW        = $clog2(FD + 1);
    localparam logic [31:0] MEM_BYTES = 32'(DEPTH_WORDS * 4);

    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] instr;
        logic        fault;
        logic        cause;
    } rsp_t;

    logic [31:0] mem [DEPTH_WORDS];

    logic [31:0]   off;
    logic          misaligned;
    logic          out_of_range;
    logic          req_fault;
    logic          req_cause;
    logic [AW-1:0] rd_idx;

    assign off          = req_addr - BASE_ADDR;
    assign misaligned   = req_addr[1:0] != 2'b00;
    assign out_of_range = off >= MEM_BYTES;
    assign req_fault    = misaligned | out_of_range;
    assign req_cause    = !misaligned && out_of_range;
    assign rd_idx       = off[AW+1:2];

    logic          ready_en_q;
    logic          s_valid_q [1:READ_LAT];
    logic [31:0]   s_addr_q  [1:READ_LAT];
    logic          s_fault_q [1:READ_LAT];
    logic          s_cause_q [1:READ_LAT];
    logic [31:0]   s_instr_q [1:READ_LAT];
    logic [CW-1:0] inflight_q, inflight_d;
    logic [CW-1:0] fifo_count_q, fifo_count_d;
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    rsp_t          fifo_q [FD];

    rsp_t        tail;
    rsp_t        head;
    logic        fifo_empty;
    logic        pop;
    logic        fifo_pop;
    logic        push;
    logic        accept;
    int unsigned used;

    function automatic logic [PW-1:0] inc_ptr(input logic [PW-1:0] p);
        return (32'(p) == FD - 1) ? '0 : p + 1'b1;
    endfunction

    // Faulting fetches never read memory, so their stale data is replaced here.
    always_comb begin
        tail.addr  = s_addr_q[READ_LAT];
        tail.instr = s_fault_q[READ_LAT] ? NOP_INSTR : s_instr_q[READ_LAT];
        tail.fault = s_fault_q[READ_LAT];
        tail.cause = s_cause_q[READ_LAT];
    end

    always_comb begin
        fifo_empty = fifo_count_q == '0;
        rsp_valid  = !fifo_empty || s_valid_q[READ_LAT];
        head       = fifo_empty ? tail : fifo_q[rd_ptr_q];
        pop        = rsp_valid && rsp_ready;
        fifo_pop   = pop && !fifo_empty;
        // The last stage bypasses an empty FIFO when the consumer takes it immediately.
        push       = s_valid_q[READ_LAT] && !(fifo_empty && pop);
        used       = 32'(inflight_q) + 32'(fifo_count_q) - 32'(pop);
        req_ready  = ready_en_q && !flush && (used < FD);
        accept     = req_valid && req_ready;
    end

    always_comb begin
        rsp_instr = '0;
        rsp_addr  = '0;
        rsp_fault = 1'b0;
        rsp_cause = '0;
        if (rsp_valid) begin
            rsp_instr = head.instr;
            rsp_addr  = head.addr;
            rsp_fault = head.fault;
            rsp_cause = head.fault ? {3'b000, head.cause} : 4'd0;
        end
    end

    always_comb begin
        inflight_d   = inflight_q + CW'(accept) - CW'(s_valid_q[READ_LAT]);
        fifo_count_d = fifo_count_q + CW'(push) - CW'(fifo_pop);
        wr_ptr_d     = push ? inc_ptr(wr_ptr_q) : wr_ptr_q;
        rd_ptr_d     = fifo_pop ? inc_ptr(rd_ptr_q) : rd_ptr_q;
        if (flush) begin
            inflight_d   = '0;
            fifo_count_d = '0;
            wr_ptr_d     = '0;
            rd_ptr_d     = '0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ready_en_q   <= 1'b0;
            inflight_q   <= '0;
            fifo_count_q <= '0;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            for (int k = 1; k <= READ_LAT; k++) begin
                s_valid_q[k] <= 1'b0;
                s_addr_q[k]  <= '0;
                s_fault_q[k] <= 1'b0;
                s_cause_q[k] <= 1'b0;
            end
        end else begin
            ready_en_q   <= 1'b1;
            inflight_q   <= inflight_d;
            fifo_count_q <= fifo_count_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            s_valid_q[1] <= accept;
            s_addr_q[1]  <= req_addr;
            s_fault_q[1] <= req_fault;
            s_cause_q[1] <= req_cause;
            for (int k = 2; k <= READ_LAT; k++) begin
                s_valid_q[k] <= s_valid_q[k-1] && !flush;
                s_addr_q[k]  <= s_addr_q[k-1];
                s_fault_q[k] <= s_fault_q[k-1];
                s_cause_q[k] <= s_cause_q[k-1];
            end
        end
    end

    // Storage without reset: memory contents survive reset, data is qualified by valids.
    always_ff @(posedge clk) begin
        if (ld_we) mem[ld_widx] <= ld_data;
        if (accept && !req_fault) s_instr_q[1] <= mem[rd_idx];
        for (int k = 2; k <= READ_LAT; k++) begin
            s_instr_q[k] <= s_instr_q[k-1];
        end
        if (push && !flush) fifo_q[wr_ptr_q] <= tail;
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            assert (32'(inflight_q) + 32'(fifo_count_q) <= FD);
            assert (!(push && 32'(fifo_count_q) == FD));
        end
    end

endmodule

// File: tb/tb_m_imem_fetch_port.sv
// Directed bench for m_imem_fetch_port: a READ_LAT=1 instance for decode/latency/load cases and
// a READ_LAT=3 instance for credit, back-pressure and flush cases.
module tb_m_imem_fetch_port;

    logic clk = 1'b0;
    logic reset;
    logic ld_we;
    logic [9:0] ld_widx;
    logic [31:0] ld_data;

    logic flush1, req_valid1, req_ready1, rsp_valid1, rsp_ready1, rsp_fault1;
    logic [31:0] req_addr1, rsp_instr1, rsp_addr1;
    logic [3:0] rsp_cause1;
    logic flush3, req_valid3, req_ready3, rsp_valid3, rsp_ready3, rsp_fault3;
    logic [31:0] req_addr3, rsp_instr3, rsp_addr3;
    logic [3:0] rsp_cause3;

    int n_checks = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    m_imem_fetch_port #(.DEPTH_WORDS(1024), .READ_LAT(1)) u_l1 (
        .clk(clk), .reset(reset), .flush(flush1),
        .req_valid(req_valid1), .req_ready(req_ready1), .req_addr(req_addr1),
        .rsp_valid(rsp_valid1), .rsp_ready(rsp_ready1), .rsp_instr(rsp_instr1),
        .rsp_addr(rsp_addr1), .rsp_fault(rsp_fault1), .rsp_cause(rsp_cause1),
        .ld_we(ld_we), .ld_widx(ld_widx), .ld_data(ld_data)
    );

    m_imem_fetch_port #(.DEPTH_WORDS(1024), .READ_LAT(3)) u_l3 (
        .clk(clk), .reset(reset), .flush(flush3),
        .req_valid(req_valid3), .req_ready(req_ready3), .req_addr(req_addr3),
        .rsp_valid(rsp_valid3), .rsp_ready(rsp_ready3), .rsp_instr(rsp_instr3),
        .rsp_addr(rsp_addr3), .rsp_fault(rsp_fault3), .rsp_cause(rsp_cause3),
        .ld_we(ld_we), .ld_widx(ld_widx), .ld_data(ld_data)
    );

    typedef struct {
        logic [31:0] addr;
        logic [31:0] instr;
        logic        fault;
        logic [3:0]  cause;
    } vec_t;

    vec_t vecs[8];
    logic [31:0] words[8];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual %h required %h", name, act, exp);
        end
    endtask

    task automatic checkb(input string name, input logic act, input logic exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual %b required %b", name, act, exp);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        int acc, got, lat, nrsp;
        logic rdy;
        logic [31:0] first_instr, first_addr;

        words[0] = 32'h8000_0537; words[1] = 32'h0010_0093;
        words[2] = 32'h0020_0113; words[3] = 32'h0030_8193;
        words[4] = 32'h0040_0213; words[5] = 32'h1111_1111;
        words[6] = 32'h2222_2222; words[7] = 32'h3333_3333;

        vecs[0] = '{32'h8000_0008, 32'h0020_0113, 1'b0, 4'd0};
        vecs[1] = '{32'h8000_0002, 32'h0000_0013, 1'b1, 4'd0};
        vecs[2] = '{32'h8000_1000, 32'h0000_0013, 1'b1, 4'd1};
        vecs[3] = '{32'h7FFF_FFFC, 32'h0000_0013, 1'b1, 4'd1};
        vecs[4] = '{32'h8000_0FFC, 32'hCAFE_F00D, 1'b0, 4'd0};
        vecs[5] = '{32'h8000_1001, 32'h0000_0013, 1'b1, 4'd0};
        vecs[6] = '{32'h8000_0010, 32'h0040_0213, 1'b0, 4'd0};
        vecs[7] = '{32'h0000_0000, 32'h0000_0013, 1'b1, 4'd1};

        reset = 1'b1; ld_we = 1'b0; ld_widx = '0; ld_data = '0;
        flush1 = 1'b0; req_valid1 = 1'b0; req_addr1 = '0; rsp_ready1 = 1'b1;
        flush3 = 1'b0; req_valid3 = 1'b0; req_addr3 = '0; rsp_ready3 = 1'b0;

        #3;
        checkb("rst_rsp_valid1", rsp_valid1, 1'b0);
        checkb("rst_req_ready1", req_ready1, 1'b0);
        checkb("rst_req_ready3", req_ready3, 1'b0);
        check("rst_rsp_instr1", rsp_instr1, 32'h0);
        repeat (2) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        checkb("post_rst_ready1", req_ready1, 1'b1);
        checkb("post_rst_ready3", req_ready3, 1'b1);

        // Program load
        for (int k = 0; k < 8; k++) begin
            ld_we = 1'b1; ld_widx = 10'(k); ld_data = words[k];
            @(negedge clk);
        end
        ld_widx = 10'd1023; ld_data = 32'hCAFE_F00D;
        @(negedge clk);
        ld_we = 1'b0;

        // Back-to-back fetches, READ_LAT=1
        req_valid1 = 1'b1; req_addr1 = 32'h8000_0000;
        #1 checkb("b2b_ready", req_ready1, 1'b1);
        @(negedge clk);
        checkb("b2b_valid0", rsp_valid1, 1'b1);
        check("b2b_instr0", rsp_instr1, words[0]);
        check("b2b_addr0", rsp_addr1, 32'h8000_0000);
        req_addr1 = 32'h8000_0004;
        @(negedge clk);
        checkb("b2b_valid1", rsp_valid1, 1'b1);
        check("b2b_instr1", rsp_instr1, words[1]);
        check("b2b_addr1", rsp_addr1, 32'h8000_0004);
        req_valid1 = 1'b0;
        @(negedge clk);
        checkb("b2b_idle", rsp_valid1, 1'b0);

        // Decode table
        for (int i = 0; i < 8; i++) begin
            req_valid1 = 1'b1; req_addr1 = vecs[i].addr;
            @(negedge clk);
            req_valid1 = 1'b0;
            checkb($sformatf("vec%0d_valid", i), rsp_valid1, 1'b1);
            check($sformatf("vec%0d_instr", i), rsp_instr1, vecs[i].instr);
            check($sformatf("vec%0d_addr", i), rsp_addr1, vecs[i].addr);
            checkb($sformatf("vec%0d_fault", i), rsp_fault1, vecs[i].fault);
            check($sformatf("vec%0d_cause", i), 32'(rsp_cause1), 32'(vecs[i].cause));
        end

        // Load write racing a read of the same word
        ld_we = 1'b1; ld_widx = 10'd5; ld_data = 32'hDEAD_BEEF;
        req_valid1 = 1'b1; req_addr1 = 32'h8000_0014;
        @(negedge clk);
        ld_we = 1'b0;
        check("ld_read_first", rsp_instr1, words[5]);
        @(negedge clk);
        req_valid1 = 1'b0;
        check("ld_new_data", rsp_instr1, 32'hDEAD_BEEF);
        @(negedge clk);

        // Credit limit, READ_LAT=3, consumer stalled
        acc = 0;
        for (int c = 0; c < 8; c++) begin
            req_valid3 = 1'b1; req_addr3 = 32'h8000_0000 + 32'(4 * acc);
            #1 rdy = req_ready3;
            @(negedge clk);
            if (rdy) acc++;
        end
        check("bp_accepts", 32'(acc), 32'd4);
        #1 checkb("bp_ready_low", req_ready3, 1'b0);
        checkb("bp_head_valid", rsp_valid3, 1'b1);
        check("bp_head_addr", rsp_addr3, 32'h8000_0000);
        req_valid3 = 1'b0; rsp_ready3 = 1'b1;
        got = 0;
        for (int c = 0; c < 12; c++) begin
            if (rsp_valid3 && got < 8) begin
                check($sformatf("drain%0d_instr", got), rsp_instr3, words[got]);
                check($sformatf("drain%0d_addr", got), rsp_addr3, 32'h8000_0000 + 32'(4 * got));
                got++;
            end
            @(negedge clk);
        end
        check("drain_count", 32'(got), 32'd4);
        rsp_ready3 = 1'b0;

        // Flush with 2 in flight and 2 queued
        for (int c = 0; c < 4; c++) begin
            req_valid3 = 1'b1; req_addr3 = 32'h8000_0000 + 32'(4 * c);
            #1 checkb($sformatf("fl_acc%0d", c), req_ready3, 1'b1);
            @(negedge clk);
        end
        req_valid3 = 1'b0;
        @(negedge clk);
        flush3 = 1'b1; req_valid3 = 1'b1; req_addr3 = 32'h8000_000C;
        #1 checkb("fl_ready_low", req_ready3, 1'b0);
        @(negedge clk);
        flush3 = 1'b0; req_valid3 = 1'b0;
        checkb("fl_rsp_cleared", rsp_valid3, 1'b0);
        nrsp = 0;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            if (rsp_valid3) nrsp++;
        end
        check("fl_no_stale", 32'(nrsp), 32'd0);
        rsp_ready3 = 1'b1; req_valid3 = 1'b1; req_addr3 = 32'h8000_0010;
        @(negedge clk);
        req_valid3 = 1'b0;
        nrsp = 0; lat = 0; first_instr = '0; first_addr = '0;
        for (int c = 1; c <= 8; c++) begin
            if (rsp_valid3) begin
                if (nrsp == 0) begin
                    lat = c; first_instr = rsp_instr3; first_addr = rsp_addr3;
                end
                nrsp++;
            end
            @(negedge clk);
        end
        check("fl_post_count", 32'(nrsp), 32'd1);
        check("fl_post_lat", 32'(lat), 32'd3);
        check("fl_post_instr", first_instr, words[4]);
        check("fl_post_addr", first_addr, 32'h8000_0010);

        // Asynchronous reset mid-stream
        req_valid1 = 1'b1; req_addr1 = 32'h8000_0000;
        @(negedge clk);
        req_valid1 = 1'b0;
        checkb("mr_pre_valid", rsp_valid1, 1'b1);
        #2 reset = 1'b1;
        #1;
        checkb("mr_rsp_valid", rsp_valid1, 1'b0);
        check("mr_rsp_instr", rsp_instr1, 32'h0);
        check("mr_rsp_addr", rsp_addr1, 32'h0);
        checkb("mr_req_ready", req_ready1, 1'b0);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        checkb("mr_ready_back", req_ready1, 1'b1);
        req_valid1 = 1'b1; req_addr1 = 32'h8000_0014;
        @(negedge clk);
        req_valid1 = 1'b0;
        checkb("mr_mem_valid", rsp_valid1, 1'b1);
        check("mr_mem_kept", rsp_instr1, 32'hDEAD_BEEF);
        @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
